// File: rtl/quad_key_fifo_if.sv
// Head-of-queue key handshake between quad_key_fifo and its consumer.
interface quad_key_fifo_if;
  logic [1:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_code,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/quad_key_fifo.sv
// Encodes one-hot debounced key pulses into 2-bit codes and queues them
// in a first-word-fall-through FIFO drained over a valid/ready handshake.
module quad_key_fifo #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic                sysclk,
  input  logic                reset,
  input  logic                X0_deb,
  input  logic                X1_deb,
  input  logic                X2_deb,
  input  logic                X3_deb,
  input  logic                clr_flags,
  quad_key_fifo_if.master     kif,
  output logic [AW:0]         fifo_count,
  output logic                overflow,
  output logic                multi_err
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          mer_q, mer_d;

  logic          push_req;
  logic          multi;
  logic [1:0]    code;
  logic          full;
  logic          valid;
  logic          pop;
  logic          do_push;

  assign push_req = X0_deb | X1_deb | X2_deb | X3_deb;
  assign multi    = (X0_deb & (X1_deb | X2_deb | X3_deb))
                  | (X1_deb & (X2_deb | X3_deb))
                  | (X2_deb & X3_deb);

  // Lowest index wins when several keys collide
  always_comb begin
    code = 2'd0;
    if (X0_deb)      code = 2'd0;
    else if (X1_deb) code = 2'd1;
    else if (X2_deb) code = 2'd2;
    else if (X3_deb) code = 2'd3;
  end

  assign full    = (cnt_q == FULL_CNT);
  assign valid   = (cnt_q != '0);
  assign pop     = valid & kif.key_ready;
  assign do_push = push_req & (~full | pop);

  always_comb begin
    cnt_d = cnt_q;
    if (do_push & ~pop)      cnt_d = cnt_q + 1'b1;
    else if (pop & ~do_push) cnt_d = cnt_q - 1'b1;
  end

  // A set event in the same cycle overrides the clear
  assign ovf_d = (push_req & full & ~pop) | (ovf_q & ~clr_flags);
  assign mer_d = multi | (mer_q & ~clr_flags);

  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      mer_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wp_q] <= code;
        wp_q        <= wp_q + 1'b1;
      end
      if (pop) rp_q <= rp_q + 1'b1;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      mer_q <= mer_d;
    end
  end

  assign kif.key_code  = mem_q[rp_q];
  assign kif.key_valid = valid;
  assign fifo_count    = cnt_q;
  assign overflow      = ovf_q;
  assign multi_err     = mer_q;

endmodule

// File: tb/tb_quad_key_fifo.sv
// Directed bench for quad_key_fifo: ordering, full/overflow,
// multi-key collisions, async reset and pointer wrap.
module tb_quad_key_fifo;

  logic       clk;
  logic       rst;
  logic       x0, x1, x2, x3;
  logic       clr;
  logic [2:0] cnt;
  logic       ovf;
  logic       mer;

  int nvec;
  int nerr;

  quad_key_fifo_if kif ();

  quad_key_fifo #(.DEPTH(4), .AW(2)) dut (
    .sysclk     (clk),
    .reset      (rst),
    .X0_deb     (x0),
    .X1_deb     (x1),
    .X2_deb     (x2),
    .X3_deb     (x3),
    .clr_flags  (clr),
    .kif        (kif),
    .fifo_count (cnt),
    .overflow   (ovf),
    .multi_err  (mer)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic [3:0] x,
                      input logic rdy,
                      input logic c);
    {x3, x2, x1, x0} = x;
    kif.key_ready = rdy;
    clr = c;
    @(negedge clk);
    {x3, x2, x1, x0} = 4'b0;
    clr = 1'b0;
  endtask

  logic [1:0] exp_seq [4];
  logic [1:0] mq [$];
  logic [1:0] c;
  logic       psh;
  logic       rdy;

  initial begin
    nvec = 0;
    nerr = 0;
    rst = 1'b1;
    {x3, x2, x1, x0} = 4'b0;
    clr = 1'b0;
    kif.key_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // reset values
    chk("rst_valid", 32'(kif.key_valid), 0);
    chk("rst_count", 32'(cnt), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_merr", 32'(mer), 0);
    chk("rst_code", 32'(kif.key_code), 0);

    // single X2 press, then hold
    tick(4'b0100, 1'b0, 1'b0);
    chk("x2_valid", 32'(kif.key_valid), 1);
    chk("x2_code", 32'(kif.key_code), 2);
    chk("x2_count", 32'(cnt), 1);
    for (int i = 0; i < 5; i++) tick(4'b0000, 1'b0, 1'b0);
    chk("hold_valid", 32'(kif.key_valid), 1);
    chk("hold_code", 32'(kif.key_code), 2);
    chk("hold_count", 32'(cnt), 1);
    tick(4'b0000, 1'b1, 1'b0);
    chk("pop1_count", 32'(cnt), 0);
    chk("pop1_valid", 32'(kif.key_valid), 0);

    // order 0,3,1,2
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b1000, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    chk("ord_count", 32'(cnt), 4);
    exp_seq = '{2'd0, 2'd3, 2'd1, 2'd2};
    for (int i = 0; i < 4; i++) begin
      chk("ord_code", 32'(kif.key_code), 32'(exp_seq[i]));
      tick(4'b0000, 1'b1, 1'b0);
    end
    chk("ord_valid", 32'(kif.key_valid), 0);
    chk("ord_count0", 32'(cnt), 0);

    // full: overflow, then push with pop
    tick(4'b0001, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0);
    chk("full_count", 32'(cnt), 4);
    chk("full_ovf0", 32'(ovf), 0);
    tick(4'b1000, 1'b0, 1'b0);
    chk("ovf_set", 32'(ovf), 1);
    chk("ovf_count", 32'(cnt), 4);
    chk("ovf_head", 32'(kif.key_code), 0);
    tick(4'b1000, 1'b1, 1'b0);
    chk("pp_count", 32'(cnt), 4);
    exp_seq = '{2'd1, 2'd2, 2'd0, 2'd3};
    for (int i = 0; i < 4; i++) begin
      chk("pp_code", 32'(kif.key_code), 32'(exp_seq[i]));
      tick(4'b0000, 1'b1, 1'b0);
    end
    chk("pp_empty", 32'(cnt), 0);
    chk("ovf_sticky", 32'(ovf), 1);
    tick(4'b0000, 1'b0, 1'b1);
    chk("ovf_clr", 32'(ovf), 0);

    // multi-key collisions
    tick(4'b1010, 1'b0, 1'b0);
    chk("multi_count", 32'(cnt), 1);
    chk("multi_code", 32'(kif.key_code), 1);
    chk("multi_set", 32'(mer), 1);
    tick(4'b0000, 1'b0, 1'b1);
    chk("multi_clr", 32'(mer), 0);
    tick(4'b0011, 1'b0, 1'b1);
    chk("multi_win", 32'(mer), 1);
    chk("multi_count2", 32'(cnt), 2);
    chk("multi_noovf", 32'(ovf), 0);
    tick(4'b0000, 1'b1, 1'b0);
    chk("multi_head2", 32'(kif.key_code), 0);
    tick(4'b0000, 1'b1, 1'b1);
    chk("multi_drain", 32'(cnt), 0);
    chk("multi_clr2", 32'(mer), 0);

    // async reset mid-queue
    tick(4'b0011, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0);
    chk("pre_rst_count", 32'(cnt), 3);
    chk("pre_rst_merr", 32'(mer), 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(kif.key_valid), 0);
    chk("arst_count", 32'(cnt), 0);
    chk("arst_merr", 32'(mer), 0);
    chk("arst_ovf", 32'(ovf), 0);
    @(negedge clk);
    rst = 1'b0;
    tick(4'b0001, 1'b0, 1'b0);
    chk("post_rst_code", 32'(kif.key_code), 0);
    chk("post_rst_count", 32'(cnt), 1);
    tick(4'b0000, 1'b1, 1'b0);
    chk("post_rst_empty", 32'(cnt), 0);

    // wrap-around against a queue model
    mq.delete();
    for (int i = 0; i < 20; i++) begin
      psh = (i % 2 == 0);
      rdy = (i % 4 != 0);
      c = 2'($urandom_range(0, 3));
      chk("wrap_valid", 32'(kif.key_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) chk("wrap_code", 32'(kif.key_code), 32'(mq[0]));
      if (rdy && mq.size() > 0) void'(mq.pop_front());
      if (psh && mq.size() < 4) mq.push_back(c);
      tick(psh ? (4'b0001 << c) : 4'b0000, rdy, 1'b0);
      chk("wrap_count", 32'(cnt), 32'(mq.size()));
    end
    for (int i = 0; i < 6; i++) begin
      chk("drain_valid", 32'(kif.key_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("drain_code", 32'(kif.key_code), 32'(mq[0]));
        void'(mq.pop_front());
      end
      tick(4'b0000, 1'b1, 1'b0);
    end
    chk("wrap_count0", 32'(cnt), 0);
    chk("wrap_ovf", 32'(ovf), 0);
    chk("wrap_merr", 32'(mer), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/quad_key_fifo.md
# quad_key_fifo

Consumer end of the quad debounced-key interface. Takes the four single-cycle, one-hot key pulses produced by the debouncer (`X0_deb`..`X3_deb`) and encodes each pulse into a 2-bit key code. Queues the codes in a small first-word-fall-through FIFO and presents them to downstream logic (menu/game FSM) over a valid/ready handshake. Sits between the debouncer and any block that must not miss a key press while busy.

## Interface
- `DEPTH`, 4, number of FIFO entries; power of two, ≥2
- `AW`, 2, log2(`DEPTH`); pointer width
- `sysclk` in 1 system clock; all logic on rising edge
- `reset` in 1 asynchronous, active-high reset
- `X0_deb`..`X3_deb` in 1 each: single-cycle key pulses from the debouncer
- `key_ready` in 1 downstream ready to accept the head entry
- `clr_flags` in 1 synchronous clear of `overflow` and `multi_err`
- `key_code` out 2 head-of-queue key code (0..3 = X0..X3)
- `key_valid` out 1 queue non-empty; `key_code` is valid
- `fifo_count` out AW+1 entries currently stored, 0..`DEPTH`
- `overflow` out 1 sticky: a key pulse was dropped because the queue was full
- `multi_err` out 1 sticky: more than one key pulse arrived in the same cycle

## Operation
- Push request: any `Xn_deb` high in a cycle. Encoded code = index of lowest-numbered asserted input (priority X0 > X1 > X2 > X3).
- Two or more inputs high in one cycle: push the lowest index only, set `multi_err`.
- Pop: `key_valid & key_ready` at a clock edge; head advances.
- Storage: `DEPTH`×2-bit register array, write pointer and read pointer of AW bits, wrapping modulo `DEPTH`. `fifo_count` is a separate AW+1-bit counter: +1 on push only, −1 on pop only, unchanged on both or neither.
- Full (`fifo_count == DEPTH`):
  - push without pop: pulse dropped, `overflow` set, contents/pointers unchanged
  - push with pop: both occur, count stays `DEPTH`, new code written to freed slot
- Empty: `key_valid` low; `key_ready` ignored; pop never occurs. Push into empty has no bypass.
- `key_code` when `key_valid` low: holds the stale array value; don't-care for verification.
- `clr_flags`: clears both sticky flags at the next edge. A set event in the same cycle wins; the flag stays 1.
- `reset` asserted (any time, incl. mid-queue): pointers, count, flags → 0 immediately; queued keys discarded. Array contents need not reset.

## Timing
- Reset values: `key_valid`=0, `fifo_count`=0, `overflow`=0, `multi_err`=0, `key_code`=0.
- Push latency: pulse in cycle N → `key_valid`=1, `key_code` updated, `fifo_count` incremented in cycle N+1.
- Pop: `key_ready` sampled at edge ending cycle M → next entry (or `key_valid`=0) visible in cycle M+1.
- `key_code` and `key_valid` come from registers/array only. No combinational path from any input to any output.
- Back-to-back pulses (every cycle) and pops every cycle are supported; sustained push+pop at 1 entry/cycle with count constant.
- Flags update one edge after the causing event.

## Test plan
- Reset, then pulse X2 for one cycle with `key_ready`=0 → next cycle: `key_valid`=1, `key_code`=2, `fifo_count`=1. Hold 5 cycles → unchanged.
- Pulses X0, X3, X1, X2 on consecutive cycles with `key_ready`=0, then `key_ready`=1 → `key_code` sequence 0,3,1,2 on successive cycles, then `key_valid`=0, `fifo_count`=0.
- Fill 4 entries, pulse X3 with `key_ready`=0 → `overflow`=1, `fifo_count`=4, head unchanged. Pulse X3 with `key_ready`=1 → count stays 4, last entry = 3.
- X1 and X3 high in the same cycle → single entry with code 1, `multi_err`=1. `clr_flags` one cycle → `multi_err`=0. `clr_flags` coincident with a new double pulse → `multi_err` stays 1.
- Queue holding 3 entries, assert `reset` asynchronously mid-cycle → `key_valid`, `fifo_count`, flags go to 0 before the next edge. After release, pulse X0 → `key_code`=0, count=1.
- Wrap-around: 10 push/pop pairs with random codes, `key_ready` toggling → output order matches input order, count never exceeds 4, no flags set.
